// File: rtl/enc8to3_seq.sv
// enc8to3_seq
// Sequential 8-to-3 encoder. It accepts one multi-hot request word and emits
// the 3-bit index of every set bit, one index per output handshake. With
// LSB_FIRST=1 the lowest set index comes out first. With LSB_FIRST=0 the
// highest set index comes out first.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high
//   in_vld   request word valid
//   in_rdy   block can accept a request word (idle and not in reset)
//   in       8-bit multi-hot request word
//   out_vld  out/last valid
//   out_rdy  consumer accepts out
//   out      encoded index of the current set bit
//   last     current index is the final one of this word
//   none     one-cycle pulse: an all-zero word was accepted
//   cnt      popcount of the word being processed
module enc8to3_seq #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_vld,
    output logic       in_rdy,
    input  logic [7:0] in,
    output logic       out_vld,
    input  logic       out_rdy,
    output logic [2:0] out,
    output logic       last,
    output logic       none,
    output logic [3:0] cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [3:0] cnt_q, cnt_d;
    logic       none_q, none_d;

    logic [2:0] sel_idx;
    logic       one_left;

    // Number of set bits in a request word (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] w);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, w[i]};
        end
        return c;
    endfunction

    // Index of the set bit that goes out next. A later loop iteration
    // overwrites an earlier one, so the scan direction sets the priority.
    always_comb begin
        sel_idx = 3'd0;
        if (LSB_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (pend_q[i]) sel_idx = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (pend_q[i]) sel_idx = 3'(i);
            end
        end
    end

    // Exactly one bit is still pending. That bit is the last one of the word.
    assign one_left = (pend_q != 8'd0) && ((pend_q & (pend_q - 8'd1)) == 8'd0);

    // Next-state logic. A nonzero word is captured only from IDLE. An all-zero
    // word is dropped and reported through the one-cycle none pulse. In SCAN,
    // a pending bit is removed only when the consumer accepts its index.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        none_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_vld) begin
                    if (in != 8'd0) begin
                        pend_d  = in;
                        cnt_d   = popcount8(in);
                        state_d = SCAN;
                    end else begin
                        cnt_d  = 4'd0;
                        none_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_rdy) begin
                    if (one_left) begin
                        pend_d  = 8'd0;
                        state_d = IDLE;
                    end else begin
                        pend_d = pend_q & ~(8'd1 << sel_idx);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = 8'd0;
            end
        endcase
    end

    // State registers. Reset takes priority over everything. A reset in the
    // middle of a scan discards the indices that are still pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 8'd0;
            cnt_q   <= 4'd0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            none_q  <= none_d;
        end
    end

    assign in_rdy  = (state_q == IDLE) && !rst;
    assign out_vld = (state_q == SCAN);
    assign out     = (state_q == SCAN) ? sel_idx : 3'd0;
    assign last    = (state_q == SCAN) && one_left;
    assign none    = none_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_enc8to3_seq.sv
// tb_enc8to3_seq
// Directed bench for enc8to3_seq. One instance uses LSB-first order and one
// uses MSB-first order. Both instances get the same inputs, so every
// transaction checks both emission orders side by side.
module tb_enc8to3_seq;

    logic       clk;
    logic       rst;
    logic       in_vld;
    logic [7:0] in;
    logic       out_rdy;

    logic       lsb_in_rdy, lsb_out_vld, lsb_last, lsb_none;
    logic [2:0] lsb_out;
    logic [3:0] lsb_cnt;
    logic       msb_in_rdy, msb_out_vld, msb_last, msb_none;
    logic [2:0] msb_out;
    logic [3:0] msb_cnt;

    int tests_run;
    int tests_failed;

    enc8to3_seq #(.LSB_FIRST(1'b1)) u_lsb (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (lsb_in_rdy),
        .in      (in),
        .out_vld (lsb_out_vld),
        .out_rdy (out_rdy),
        .out     (lsb_out),
        .last    (lsb_last),
        .none    (lsb_none),
        .cnt     (lsb_cnt)
    );

    enc8to3_seq #(.LSB_FIRST(1'b0)) u_msb (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (msb_in_rdy),
        .in      (in),
        .out_vld (msb_out_vld),
        .out_rdy (out_rdy),
        .out     (msb_out),
        .last    (msb_last),
        .none    (msb_none),
        .cnt     (msb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive the shared inputs. Called just after a falling edge.
    task automatic applyStimulus(input logic vld, input logic [7:0] word,
                                 input logic rdy);
        in_vld  = vld;
        in      = word;
        out_rdy = rdy;
    endtask

    // Expected index sequences for 8'b1010_0101.
    logic [2:0] seq_lsb [4];
    logic [2:0] seq_msb [4];

    initial begin
        int delivered;
        logic [7:0] seen;
        logic [3:0] rdy_pat;

        tests_run    = 0;
        tests_failed = 0;
        seq_lsb = '{3'd0, 3'd2, 3'd5, 3'd7};
        seq_msb = '{3'd7, 3'd5, 3'd2, 3'd0};

        // Reset held for two cycles.
        rst = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("rst_out_vld_lsb", {31'd0, lsb_out_vld}, 0);
            checkOutput("rst_in_rdy_lsb",  {31'd0, lsb_in_rdy},  0);
            checkOutput("rst_in_rdy_msb",  {31'd0, msb_in_rdy},  0);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_in_rdy", {31'd0, lsb_in_rdy}, 1);
        checkOutput("post_rst_cnt",    {28'd0, lsb_cnt},    0);
        checkOutput("post_rst_none",   {31'd0, lsb_none},   0);
        checkOutput("post_rst_out",    {29'd0, lsb_out},    0);

        // 8'b1010_0101 with the consumer always ready.
        applyStimulus(1'b1, 8'b1010_0101, 1'b1);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("a5_vld_lsb",  {31'd0, lsb_out_vld}, 1);
            checkOutput("a5_out_lsb",  {29'd0, lsb_out},     {29'd0, seq_lsb[i]});
            checkOutput("a5_out_msb",  {29'd0, msb_out},     {29'd0, seq_msb[i]});
            checkOutput("a5_last_lsb", {31'd0, lsb_last},    (i == 3) ? 1 : 0);
            checkOutput("a5_last_msb", {31'd0, msb_last},    (i == 3) ? 1 : 0);
            checkOutput("a5_cnt",      {28'd0, lsb_cnt},     4);
            checkOutput("a5_in_rdy",   {31'd0, lsb_in_rdy},  0);
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("a5_done_vld", {31'd0, lsb_out_vld}, 0);
        checkOutput("a5_done_rdy", {31'd0, lsb_in_rdy},  1);
        checkOutput("a5_done_out", {29'd0, msb_out},     0);

        // A single-bit word.
        applyStimulus(1'b1, 8'b0000_1000, 1'b1);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 8'd0, 1'b1);
        checkOutput("one_out_lsb",  {29'd0, lsb_out},  3);
        checkOutput("one_out_msb",  {29'd0, msb_out},  3);
        checkOutput("one_last_msb", {31'd0, msb_last}, 1);
        checkOutput("one_cnt",      {28'd0, msb_cnt},  1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("one_done_vld", {31'd0, msb_out_vld}, 0);

        // All ones with out_rdy following the pattern 1,0,0,1.
        rdy_pat = 4'b1001;
        applyStimulus(1'b1, 8'hFF, 1'b0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 8'd0, 1'b0);
        delivered = 0;
        seen      = 8'd0;
        for (int c = 0; c < 40 && lsb_out_vld; c++) begin
            checkOutput("bp_out_lsb",  {29'd0, lsb_out},  delivered);
            checkOutput("bp_out_msb",  {29'd0, msb_out},  7 - delivered);
            checkOutput("bp_last_lsb", {31'd0, lsb_last}, (delivered == 7) ? 1 : 0);
            checkOutput("bp_cnt",      {28'd0, lsb_cnt},  8);
            out_rdy = rdy_pat[3 - (c % 4)];
            if (out_rdy) begin
                seen[lsb_out] = 1'b1;
                delivered++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("bp_delivered", delivered, 8);
        checkOutput("bp_seen",      {24'd0, seen}, 32'hFF);
        checkOutput("bp_done_vld",  {31'd0, msb_out_vld}, 0);

        // An all-zero word is dropped and pulses none for one cycle.
        applyStimulus(1'b1, 8'd0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 8'd0, 1'b1);
        checkOutput("zero_none",   {31'd0, lsb_none},    1);
        checkOutput("zero_vld",    {31'd0, lsb_out_vld}, 0);
        checkOutput("zero_in_rdy", {31'd0, lsb_in_rdy},  1);
        checkOutput("zero_cnt",    {28'd0, lsb_cnt},     0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("zero_none_end", {31'd0, msb_none},    0);
        checkOutput("zero_vld_end",  {31'd0, msb_out_vld}, 0);

        // Reset in the middle of a scan discards the pending indices.
        applyStimulus(1'b1, 8'b0110_0000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("mid_vld",     {31'd0, lsb_out_vld}, 1);
        checkOutput("mid_out_lsb", {29'd0, lsb_out},     5);
        checkOutput("mid_out_msb", {29'd0, msb_out},     6);
        checkOutput("mid_cnt",     {28'd0, lsb_cnt},     2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_rst_vld",    {31'd0, lsb_out_vld}, 0);
        checkOutput("mid_rst_in_rdy", {31'd0, lsb_in_rdy},  0);
        rst = 1'b0;
        #1;
        checkOutput("mid_rel_in_rdy", {31'd0, lsb_in_rdy}, 1);
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("mid_no_emit_lsb", {31'd0, lsb_out_vld}, 0);
            checkOutput("mid_no_emit_msb", {31'd0, msb_out_vld}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/enc8to3_seq.md
Name: enc8to3_seq

Overview:
- Sequential 8-to-3 encoder: the inverse of the team's 3-to-8 decoders.
- Accepts an 8-bit multi-hot request word over a valid/ready handshake.
- Emits the 3-bit index of every set bit, one index per output handshake, in priority order.
- Sits between request-collection logic and any consumer of binary indices (e.g. a decoder driving selects).

Parameters:
- LSB_FIRST, 1: 1 = emit lowest set index first; 0 = emit highest set index first.

Ports:
- clk      input   1  rising-edge clock
- rst      input   1  synchronous reset, active-high
- in_vld   input   1  request word valid
- in_rdy   output  1  block can accept a request word
- in       input   8  multi-hot request word
- out_vld  output  1  out/last valid
- out_rdy  input   1  consumer accepts out
- out      output  3  encoded index of the current set bit
- last     output  1  current index is the final one of this word
- none     output  1  one-cycle pulse: an all-zero word was accepted
- cnt      output  4  popcount of the word being processed, 0..8

Behaviour:
- Registers:
  - state: IDLE or SCAN.
  - pend[7:0]: bits not yet emitted.
  - cnt[3:0].
  - none.
- Reset, while rst=1 at a clock edge:
  - state=IDLE, pend=0, cnt=0, none=0.
  - Resulting outputs: out_vld=0, out=0, last=0.
  - in_rdy=0 while rst is high.
  - rst overrides everything. Mid-SCAN reset discards pend with no further out_vld.
- in_rdy = (state==IDLE) && !rst.
- out_vld = (state==SCAN).
- IDLE:
  - Edge with in_vld && in_rdy && in!=0: pend<=in, cnt<=popcount(in), state<=SCAN.
  - Edge with in_vld && in_rdy && in==0: word dropped, none<=1 for exactly one cycle, state stays IDLE, cnt<=0.
  - none is 0 in every other cycle.
- SCAN:
  - out = index of the lowest (LSB_FIRST=1) or highest (LSB_FIRST=0) set bit of pend. Combinational from the pend register, so it is valid in the same cycle as out_vld.
  - last = 1 iff pend has exactly one bit set.
  - out_vld && !out_rdy: pend, out and last hold stable (no change until accepted).
  - out_vld && out_rdy: the emitted bit is cleared in pend. If last=1, state<=IDLE and pend<=0.
  - cnt holds its captured value for the whole SCAN; it is not decremented.
- Latency:
  - Word accepted at edge k -> out_vld=1 in the cycle after edge k.
  - With out_rdy held 1: N set bits give N consecutive out cycles.
  - in_rdy returns 1 the cycle after the last handshake. No input bypass; minimum period per nonzero word is N+1 cycles.
- in is ignored whenever in_rdy=0. in_vld may be held high; the next word is taken on the first IDLE edge.
- Outside SCAN: out=0 and last=0.

Test Plan:
- Reset with rst=1 for 2 cycles -> out_vld=0, in_rdy=0 during reset. First cycle after release: in_rdy=1, cnt=0, none=0.
- LSB_FIRST=1, in=8'b1010_0101, out_rdy=1 -> out sequence 0,2,5,7 on 4 consecutive cycles, last=1 only with 7, cnt=4. in_rdy=1 on the following cycle.
- LSB_FIRST=0, in=8'b1010_0101 -> out sequence 7,5,2,0, last with 0. Then in=8'b0000_1000 -> single out=3 with last=1, cnt=1.
- Backpressure: in=8'b1111_1111, out_rdy toggled 1,0,0,1,... -> out holds stable during every out_rdy=0 cycle, all 8 indices 0..7 are delivered exactly once, and cnt=8 throughout.
- Zero word: in=0 with in_vld=1 -> none=1 for exactly one cycle, out_vld stays 0, in_rdy stays 1.
- Mid-operation reset: in=8'b0110_0000, with out_rdy=0 assert rst for 1 cycle after the first out_vld -> out_vld=0 the next cycle, in_rdy=1 after release, and index 5/6 is never emitted.
